// File: rtl/prbs_rx_checker_if.sv
// Serial receive bus of the PRBS checker: bit stream and controls in, word and
// link-quality status out.
interface prbs_rx_checker_if #(
    parameter int unsigned WORD_WIDTH    = 10,
    parameter int unsigned ERR_CNT_WIDTH = 16
);
    logic                     bit_in;
    logic                     bit_en;
    logic                     bitslip;
    logic                     err_clr;
    logic [WORD_WIDTH-1:0]    word_out;
    logic                     word_valid;
    logic                     locked;
    logic                     err_pulse;
    logic [ERR_CNT_WIDTH-1:0] err_count;

    modport master (
        output bit_in, bit_en, bitslip, err_clr,
        input  word_out, word_valid, locked, err_pulse, err_count
    );

    modport slave (
        input  bit_in, bit_en, bitslip, err_clr,
        output word_out, word_valid, locked, err_pulse, err_count
    );
endinterface

// File: rtl/prbs_rx_checker.sv
// Receive-side PRBS checker: deserialises the recovered bit stream into words and
// tracks lock / bit errors against the self-synchronising PRBS pattern.
module prbs_rx_checker #(
    parameter int unsigned POLY_LENGTH   = 9,
    parameter int unsigned POLY_TAP      = 5,
    parameter int unsigned INV_PATTERN   = 1,
    parameter int unsigned WORD_WIDTH    = 10,
    parameter int unsigned LOCK_COUNT    = 32,
    parameter int unsigned WINDOW        = 64,
    parameter int unsigned LOSS_THRESH   = 8,
    parameter int unsigned ERR_CNT_WIDTH = 16
) (
    input  logic               clk,
    input  logic               rst,
    prbs_rx_checker_if.slave   rx
);
    localparam int unsigned SEED_W  = $clog2(POLY_LENGTH + 1);
    localparam int unsigned MATCH_W = $clog2(LOCK_COUNT + 1);
    localparam int unsigned WBIT_W  = $clog2(WINDOW + 1);
    localparam int unsigned WERR_W  = $clog2(LOSS_THRESH + 1);
    localparam int unsigned BCNT_W  = $clog2(WORD_WIDTH + 1);
    localparam logic        INV_BIT = (INV_PATTERN != 0);

    typedef enum logic [1:0] {
        ST_SEED   = 2'd0,
        ST_HUNT   = 2'd1,
        ST_LOCKED = 2'd2
    } state_t;

    state_t                   state_q, state_d;
    logic [POLY_LENGTH-1:0]   h_q;
    logic [SEED_W-1:0]        seed_cnt_q;
    logic [MATCH_W-1:0]       match_cnt_q;
    logic [WBIT_W-1:0]        win_bit_q;
    logic [WERR_W-1:0]        win_err_q;
    logic [ERR_CNT_WIDTH-1:0] err_count_q;
    logic                     err_pulse_q;
    logic                     locked_q;

    logic [WORD_WIDTH-1:0]    word_sr_q;
    logic [BCNT_W-1:0]        bit_cnt_q;
    logic [WORD_WIDTH-1:0]    word_out_q;
    logic                     word_valid_q;

    logic                     d_bit;
    logic                     p_bit;
    logic                     mismatch;
    logic [WERR_W-1:0]        win_err_inc;
    logic                     seed_done;
    logic                     lock_hit;
    logic                     loss_hit;
    logic                     count_err;
    logic [WORD_WIDTH-1:0]    word_next;

    // Next-state and per-bit control strobes
    always_comb begin
        d_bit       = rx.bit_in ^ INV_BIT;
        p_bit       = h_q[POLY_LENGTH-1] ^ h_q[POLY_TAP-1];
        mismatch    = (d_bit != p_bit);
        win_err_inc = win_err_q + WERR_W'(mismatch);
        state_d     = state_q;
        seed_done   = 1'b0;
        lock_hit    = 1'b0;
        loss_hit    = 1'b0;
        count_err   = 1'b0;
        if (rx.bit_en) begin
            case (state_q)
                ST_SEED: begin
                    if (seed_cnt_q == SEED_W'(POLY_LENGTH - 1)) begin
                        state_d   = ST_HUNT;
                        seed_done = 1'b1;
                    end
                end
                ST_HUNT: begin
                    if (!mismatch && match_cnt_q == MATCH_W'(LOCK_COUNT - 1)) begin
                        state_d  = ST_LOCKED;
                        lock_hit = 1'b1;
                    end
                end
                ST_LOCKED: begin
                    count_err = mismatch;
                    if (win_err_inc == WERR_W'(LOSS_THRESH)) begin
                        state_d  = ST_SEED;
                        loss_hit = 1'b1;
                    end
                end
                default: state_d = ST_SEED;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_SEED;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            h_q         <= '0;
            seed_cnt_q  <= '0;
            match_cnt_q <= '0;
            win_bit_q   <= '0;
            win_err_q   <= '0;
            err_count_q <= '0;
            err_pulse_q <= 1'b0;
            locked_q    <= 1'b0;
        end else begin
            err_pulse_q <= count_err;
            locked_q    <= (state_d == ST_LOCKED);

            if (rx.err_clr) begin
                err_count_q <= '0;
            end else if (count_err && err_count_q != '1) begin
                err_count_q <= err_count_q + ERR_CNT_WIDTH'(1);
            end

            if (rx.bit_en) begin
                case (state_q)
                    ST_SEED: begin
                        h_q        <= {h_q[POLY_LENGTH-2:0], d_bit};
                        seed_cnt_q <= seed_done ? '0 : seed_cnt_q + SEED_W'(1);
                    end
                    ST_HUNT: begin
                        h_q <= {h_q[POLY_LENGTH-2:0], d_bit};
                        if (mismatch || lock_hit) begin
                            match_cnt_q <= '0;
                        end else begin
                            match_cnt_q <= match_cnt_q + MATCH_W'(1);
                        end
                        if (lock_hit) begin
                            win_bit_q <= '0;
                            win_err_q <= '0;
                        end
                    end
                    ST_LOCKED: begin
                        if (loss_hit) begin
                            h_q         <= '0;
                            seed_cnt_q  <= '0;
                            match_cnt_q <= '0;
                            win_bit_q   <= '0;
                            win_err_q   <= '0;
                        end else begin
                            // Free-run on the prediction so a line error never pollutes the history
                            h_q <= {h_q[POLY_LENGTH-2:0], p_bit};
                            if (win_bit_q == WBIT_W'(WINDOW - 1)) begin
                                win_bit_q <= '0;
                                win_err_q <= '0;
                            end else begin
                                win_bit_q <= win_bit_q + WBIT_W'(1);
                                win_err_q <= win_err_inc;
                            end
                        end
                    end
                    default: begin
                        h_q <= '0;
                    end
                endcase
            end
        end
    end

    // Deserialiser runs regardless of checker state; bitslip drops the bit from the word only
    assign word_next = {word_sr_q[WORD_WIDTH-2:0], rx.bit_in};

    always_ff @(posedge clk) begin
        if (rst) begin
            word_sr_q    <= '0;
            bit_cnt_q    <= '0;
            word_out_q   <= '0;
            word_valid_q <= 1'b0;
        end else begin
            word_valid_q <= 1'b0;
            if (rx.bit_en && !rx.bitslip) begin
                word_sr_q <= word_next;
                if (bit_cnt_q == BCNT_W'(WORD_WIDTH - 1)) begin
                    bit_cnt_q    <= '0;
                    word_out_q   <= word_next;
                    word_valid_q <= 1'b1;
                end else begin
                    bit_cnt_q <= bit_cnt_q + BCNT_W'(1);
                end
            end
        end
    end

    assign rx.word_out   = word_out_q;
    assign rx.word_valid = word_valid_q;
    assign rx.locked     = locked_q;
    assign rx.err_pulse  = err_pulse_q;
    assign rx.err_count  = err_count_q;

endmodule
